softmax_row_max: RTL and testbench

- Streaming consumer placed directly after the softmax input buffer. It takes one element per valid cycle and tracks the running maximum over one channel row of CH_in elements.
- When the row completes, it emits the row maximum with a one-cycle valid pulse. The following subtract/exp stage uses this value for numerically stable softmax.
- It tolerates gaps in the input stream: elements arrive in bursts of up to Tout per group, with idle cycles between groups.

---
 rtl/softmax_row_max_pkg.sv | 14 +
 rtl/softmax_smax_cmp.sv | 13 +
 rtl/softmax_row_max.sv | 127 ++++++++++++
 tb/tb_softmax_row_max.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/softmax_row_max_pkg.sv
// Shared definitions for the softmax row-maximum tracker: default widths and
// the FSM state encoding.
package softmax_row_max_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_CW = 8;

  typedef enum logic [1:0] {
    SMAX_IDLE = 2'd0,
    SMAX_ACC  = 2'd1,
    SMAX_EMIT = 2'd2
  } smax_state_e;

endpackage

// File: rtl/softmax_smax_cmp.sv
// Combinational signed max-of-two. On a tie the a operand is returned, which
// lets callers keep their accumulator unchanged.
module softmax_smax_cmp #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] y
);

  assign y = ($signed(b) > $signed(a)) ? b : a;

endmodule

// File: rtl/softmax_row_max.sv
// Streaming running-maximum over one softmax channel row. One element is taken
// per in_vld cycle, gaps are allowed, and the row maximum is presented with a
// single-cycle max_vld pulse one cycle after the last element.
//
// Handshake: in_vld/in_dat is valid-only (no ready); every in_vld cycle is
// consumed. An element arriving with no open row is dropped and flags the
// sticky err_stray. max_vld is a one-cycle pulse; max_dat holds until the next.
module softmax_row_max
  import softmax_row_max_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] CH_in,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          busy,
  output logic          max_vld,
  output logic [DW-1:0] max_dat,
  output logic          err_stray,
  output logic [1:0]    dbg_state
);

  localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  smax_state_e   state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] max_dat_q, max_dat_d;
  logic          err_q, err_d;

  logic [DW-1:0] cmp_y;
  logic [CW:0]   cnt_inc;
  logic          is_last;

  softmax_smax_cmp #(.DW(DW)) u_cmp (
    .a (acc_q),
    .b (in_dat),
    .y (cmp_y)
  );

  // cnt stops at len, so the widened increment never wraps
  assign cnt_inc = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign is_last = (cnt_inc == {1'b0, len_q});

  // Next-state: open a new row on start, fold elements while accumulating
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    max_dat_d = max_dat_q;
    err_d     = err_q;

    if (start) begin
      // start always wins, including mid-row (row abandoned) and in EMIT
      len_d = CH_in;
      cnt_d = '0;
      acc_d = NEG_MIN;
      if (CH_in == '0) begin
        state_d   = SMAX_EMIT;
        max_dat_d = NEG_MIN;
        if (in_vld) err_d = 1'b1;
      end else begin
        state_d = SMAX_ACC;
        if (in_vld) begin
          cnt_d = {{(CW-1){1'b0}}, 1'b1};
          acc_d = in_dat;
          if (CH_in == {{(CW-1){1'b0}}, 1'b1}) begin
            state_d   = SMAX_EMIT;
            max_dat_d = in_dat;
          end
        end
      end
    end else begin
      case (state_q)
        SMAX_ACC: begin
          if (in_vld) begin
            cnt_d = cnt_inc[CW-1:0];
            acc_d = cmp_y;
            if (is_last) begin
              state_d   = SMAX_EMIT;
              max_dat_d = cmp_y;
            end
          end
        end
        SMAX_EMIT: begin
          state_d = SMAX_IDLE;
          if (in_vld) err_d = 1'b1;
        end
        default: begin
          if (in_vld) err_d = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SMAX_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= NEG_MIN;
      max_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      max_dat_q <= max_dat_d;
      err_q     <= err_d;
    end
  end

  assign busy      = (state_q == SMAX_ACC);
  assign max_vld   = (state_q == SMAX_EMIT);
  assign max_dat   = max_dat_q;
  assign err_stray = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_softmax_row_max.sv
// Bench for softmax_row_max: directed scenarios followed by randomized rows,
// all outputs compared every cycle against a queue-based row model.
module tb_softmax_row_max;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam logic [DW-1:0] NEG_MIN = 16'h8000;

  // clock/reset
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] ch_in;
  logic          in_vld;
  logic [DW-1:0] in_dat;
  logic          busy, max_vld, err_stray;
  logic [DW-1:0] max_dat;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  softmax_row_max #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .CH_in     (ch_in),
    .in_vld    (in_vld),
    .in_dat    (in_dat),
    .busy      (busy),
    .max_vld   (max_vld),
    .max_dat   (max_dat),
    .err_stray (err_stray),
    .dbg_state (dbg_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // reference model: row contents kept in a queue, max computed on close
  bit            m_open;
  int            m_len;
  int            exp_q[$];
  bit            m_err;
  bit            m_vld;
  logic [DW-1:0] m_max;

  task automatic model_reset();
    m_open = 0; m_len = 0; exp_q.delete(); m_err = 0; m_vld = 0; m_max = '0;
  endtask

  task automatic model_step(input bit st, input int ch, input bit v, input logic [DW-1:0] d);
    int best;
    m_vld = 0;
    if (st) begin
      exp_q.delete();
      m_len  = ch;
      m_open = (ch != 0);
      if (ch == 0) begin
        m_vld = 1; m_max = NEG_MIN;
        if (v) m_err = 1;
      end else if (v) exp_q.push_back(int'($signed(d)));
    end else if (v) begin
      if (m_open) exp_q.push_back(int'($signed(d)));
      else m_err = 1;
    end
    if (m_open && exp_q.size() == m_len) begin
      best = -32768;
      foreach (exp_q[i]) if (exp_q[i] > best) best = exp_q[i];
      m_open = 0; m_vld = 1; m_max = best[DW-1:0];
    end
  endtask

  // driver: apply inputs for one cycle, advance the model, compare outputs
  task automatic cycle(input bit st, input int ch, input bit v, input logic [DW-1:0] d);
    start = st; ch_in = ch[CW-1:0]; in_vld = v; in_dat = d;
    @(posedge clk);
    model_step(st, ch, v, d);
    #1;
    check("max_vld",   {31'd0, max_vld},   {31'd0, m_vld});
    check("busy",      {31'd0, busy},      {31'd0, m_open});
    check("max_dat",   {16'd0, max_dat},   {16'd0, m_max});
    check("err_stray", {31'd0, err_stray}, {31'd0, m_err});
    if (max_vld) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
  endtask

  initial begin
    int ch, guard, p0;
    logic [DW-1:0] d;
    logic [DW-1:0] t1 [5];
    t1[0] = 16'd3; t1[1] = -16'sd7; t1[2] = 16'd12; t1[3] = 16'd12; t1[4] = 16'd4;

    rst_n = 1'b0; start = 0; ch_in = '0; in_vld = 0; in_dat = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    {31'd0, busy},      32'd0);
    check("rst_max_vld", {31'd0, max_vld},   32'd0);
    check("rst_max_dat", {16'd0, max_dat},   32'd0);
    check("rst_err",     {31'd0, err_stray}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // row of 5 back-to-back
    cycle(1, 5, 0, '0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, t1[i]);
    check("t1_max", {16'd0, max_dat}, 32'd12);
    idle(2);

    // row of 20 in groups 8/8/4 with 3-cycle gaps, max -2
    p0 = pulses;
    cycle(1, 20, 0, '0);
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < ((g == 2) ? 4 : 8); i++)
        cycle(0, 0, 1, ((g == 1) && (i == 5)) ? 16'hFFFE : 16'(-(10 + i + 8 * g)));
      if (g < 2) idle(3);
    end
    check("t2_max", {16'd0, max_dat}, 32'h0000FFFE);
    check("t2_pulses", pulses - p0, 32'd1);
    idle(1);

    // single element at most-negative, then empty row
    cycle(1, 1, 0, '0);
    cycle(0, 0, 1, 16'h8000);
    cycle(1, 0, 0, '0);
    cycle(0, 0, 0, '0);
    idle(1);

    // start with first element, then restart in the EMIT cycle
    cycle(1, 2, 1, 16'd9);
    cycle(0, 0, 1, 16'd5);
    check("t4_max", {16'd0, max_dat}, 32'd9);
    cycle(1, 3, 1, 16'd7);
    cycle(0, 0, 1, 16'd1);
    cycle(0, 0, 1, 16'd2);
    idle(1);

    // mid-row restart
    p0 = pulses;
    cycle(1, 10, 0, '0);
    cycle(0, 0, 1, 16'd10); cycle(0, 0, 1, 16'd50);
    cycle(0, 0, 1, 16'd20); cycle(0, 0, 1, 16'd30);
    cycle(1, 3, 0, '0);
    cycle(0, 0, 1, 16'd1); cycle(0, 0, 1, 16'd2); cycle(0, 0, 1, 16'd3);
    idle(2);
    check("t5_pulses", pulses - p0, 32'd1);

    // stray element in IDLE
    cycle(0, 0, 1, 16'h1234);
    idle(3);

    // asynchronous reset mid-row
    cycle(1, 6, 1, 16'd77);
    cycle(0, 0, 1, 16'd88);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_busy",    {31'd0, busy},      32'd0);
    check("arst_max_vld", {31'd0, max_vld},   32'd0);
    check("arst_max_dat", {16'd0, max_dat},   32'd0);
    check("arst_err",     {31'd0, err_stray}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // randomized rows with gaps, strays and occasional restarts
    for (int r = 0; r < 60; r++) begin
      if ($urandom_range(0, 9) == 0) cycle(0, 0, 1, 16'($urandom));
      idle($urandom_range(0, 2));
      ch = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 24);
      cycle(1, ch, $urandom_range(0, 1), 16'($urandom));
      guard = 0;
      while (m_open && guard < 300) begin
        guard++;
        case ($urandom_range(0, 3))
          0: d = 16'($urandom_range(0, 3) == 0 ? 16'h8000 : 16'h7FFF);
          default: d = 16'($urandom);
        endcase
        if ($urandom_range(0, 39) == 0) cycle(1, $urandom_range(0, 9), $urandom_range(0, 1), d);
        else cycle(0, 0, $urandom_range(0, 3) != 0, d);
      end
      if (m_open) check("row_timeout", 32'd1, 32'd0);
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, '0);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
